// File: rtl/crono_timer.sv
// -----------------------------------------------------------------------------
// crono_timer
//
// Countdown timer engine that answers the chronometer controller's command
// bus. A programmed HH:MM:SS BCD preset is loaded on a start command and
// counted down once per TICK_DIV clock cycles. When the count reaches
// 00:00:00 the engine asserts crono_end and holds it until a stop command
// arrives. The BCD count outputs also feed the display path.
//
// Parameters
//   TICK_DIV   clk cycles per 1 s tick
//   CTRL_ADDR  dir value at which commands are accepted
//
// Ports
//   clk         in   1  system clock
//   reset       in   1  asynchronous, active-high reset
//   WR_inistop  in   1  command strobe (level, may be held for many cycles)
//   inistop     in   3  command code: 3'b101 start, 3'b110 stop, others ignored
//   dir         in   8  command address
//   set_en      in   1  one-cycle preset load strobe
//   set_hh      in   8  preset hours   (BCD 00-99)
//   set_mm      in   8  preset minutes (BCD 00-59)
//   set_ss      in   8  preset seconds (BCD 00-59)
//   crono_end   out  1  expiry flag (level)
//   running     out  1  high while counting
//   hh/mm/ss    out  8  current count, BCD
// -----------------------------------------------------------------------------
module crono_timer #(
    parameter int          TICK_DIV  = 100000000,
    parameter logic [7:0]  CTRL_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WR_inistop,
    input  logic [2:0]  inistop,
    input  logic [7:0]  dir,
    input  logic        set_en,
    input  logic [7:0]  set_hh,
    input  logic [7:0]  set_mm,
    input  logic [7:0]  set_ss,
    output logic        crono_end,
    output logic        running,
    output logic [7:0]  hh,
    output logic [7:0]  mm,
    output logic [7:0]  ss
);

    // A divider of 1 still needs a one-bit prescaler to keep the vector legal.
    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    localparam logic [2:0] CMD_START = 3'b101;
    localparam logic [2:0] CMD_STOP  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t          r_state;
    logic            r_wr_prev;
    logic            r_armed;
    logic [7:0]      r_pre_hh;
    logic [7:0]      r_pre_mm;
    logic [7:0]      r_pre_ss;
    logic [PW-1:0]   r_ps;
    logic [7:0]      r_hh;
    logic [7:0]      r_mm;
    logic [7:0]      r_ss;
    logic            r_running;
    logic            r_crono_end;

    // -------------------------------------------------------------------------
    // Next-state values
    // -------------------------------------------------------------------------
    state_t          w_state_next;
    logic [PW-1:0]   w_ps_next;
    logic [7:0]      w_hh_next;
    logic [7:0]      w_mm_next;
    logic [7:0]      w_ss_next;
    logic            w_running_next;
    logic            w_crono_end_next;

    // -------------------------------------------------------------------------
    // Command decode
    // -------------------------------------------------------------------------
    // r_armed stays low after reset until the strobe has been seen low once,
    // so a strobe still held high across reset release cannot fire a command
    // even though r_wr_prev itself was cleared by reset.
    logic w_cmd_valid;
    logic w_start;
    logic w_stop;

    assign w_cmd_valid = WR_inistop & ~r_wr_prev & r_armed & (dir == CTRL_ADDR);
    assign w_start     = w_cmd_valid & (inistop == CMD_START);
    assign w_stop      = w_cmd_valid & (inistop == CMD_STOP);

    // -------------------------------------------------------------------------
    // Preset validation: every digit 0-9, minute/second tens digit 0-5.
    // -------------------------------------------------------------------------
    logic w_set_ok;

    assign w_set_ok = (set_hh[7:4] <= 4'd9) && (set_hh[3:0] <= 4'd9) &&
                      (set_mm[7:4] <= 4'd5) && (set_mm[3:0] <= 4'd9) &&
                      (set_ss[7:4] <= 4'd5) && (set_ss[3:0] <= 4'd9);

    logic w_pre_zero;
    assign w_pre_zero = ({r_pre_hh, r_pre_mm, r_pre_ss} == 24'd0);

    // -------------------------------------------------------------------------
    // One-second BCD decrement with borrow ripple.
    // Digit order (LSD first): ss units, ss tens, mm units, mm tens, hh units,
    // hh tens. Tens of seconds and minutes wrap to 5, every other digit to 9.
    // Hours never underflow because expiry is caught at 00:00:00 first.
    // -------------------------------------------------------------------------
    logic [23:0] w_cnt;
    logic [23:0] w_dec_cnt;
    logic        w_dec_zero;

    assign w_cnt = {r_hh, r_mm, r_ss};

    always_comb begin : dec_chain
        logic v_borrow;
        w_dec_cnt = w_cnt;
        v_borrow  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (v_borrow) begin
                if (w_cnt[4*i +: 4] == 4'd0) begin
                    w_dec_cnt[4*i +: 4] = ((i == 1) || (i == 3)) ? 4'd5 : 4'd9;
                end else begin
                    w_dec_cnt[4*i +: 4] = w_cnt[4*i +: 4] - 4'd1;
                end
            end
            v_borrow = v_borrow & (w_cnt[4*i +: 4] == 4'd0);
        end
    end

    assign w_dec_zero = (w_dec_cnt == 24'd0);

    logic w_ps_last;
    assign w_ps_last = (r_ps == PS_LAST);

    // -------------------------------------------------------------------------
    // FSM next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_ps_next        = r_ps;
        w_hh_next        = r_hh;
        w_mm_next        = r_mm;
        w_ss_next        = r_ss;
        w_running_next   = r_running;
        w_crono_end_next = r_crono_end;

        if (w_start) begin
            // Start behaves identically in every state and outranks both a
            // coincident tick and any pending state: reload and restart.
            w_hh_next = r_pre_hh;
            w_mm_next = r_pre_mm;
            w_ss_next = r_pre_ss;
            w_ps_next = '0;
            if (w_pre_zero) begin
                w_state_next     = ST_DONE;
                w_running_next   = 1'b0;
                w_crono_end_next = 1'b1;
            end else begin
                w_state_next     = ST_RUN;
                w_running_next   = 1'b1;
                w_crono_end_next = 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Stop in IDLE is a no-op; the count stays frozen.
                end

                ST_RUN: begin
                    if (w_stop) begin
                        // Stop wins over a coincident tick: no decrement.
                        w_state_next   = ST_IDLE;
                        w_running_next = 1'b0;
                    end else if (w_ps_last) begin
                        w_ps_next = '0;
                        w_hh_next = w_dec_cnt[23:16];
                        w_mm_next = w_dec_cnt[15:8];
                        w_ss_next = w_dec_cnt[7:0];
                        if (w_dec_zero) begin
                            w_state_next     = ST_DONE;
                            w_running_next   = 1'b0;
                            w_crono_end_next = 1'b1;
                        end
                    end else begin
                        w_ps_next = r_ps + PW'(1);
                    end
                end

                ST_DONE: begin
                    if (w_stop) begin
                        w_state_next     = ST_IDLE;
                        w_crono_end_next = 1'b0;
                    end
                end

                default: begin
                    w_state_next     = ST_IDLE;
                    w_running_next   = 1'b0;
                    w_crono_end_next = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr_prev   <= 1'b0;
            r_armed     <= 1'b0;
            r_pre_hh    <= 8'h00;
            r_pre_mm    <= 8'h00;
            r_pre_ss    <= 8'h00;
            r_ps        <= '0;
            r_hh        <= 8'h00;
            r_mm        <= 8'h00;
            r_ss        <= 8'h00;
            r_running   <= 1'b0;
            r_crono_end <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wr_prev   <= WR_inistop;
            if (!WR_inistop) begin
                r_armed <= 1'b1;
            end
            // The preset register is read by start before this write lands,
            // so a coincident start uses the old preset.
            if (set_en && w_set_ok) begin
                r_pre_hh <= set_hh;
                r_pre_mm <= set_mm;
                r_pre_ss <= set_ss;
            end
            r_ps        <= w_ps_next;
            r_hh        <= w_hh_next;
            r_mm        <= w_mm_next;
            r_ss        <= w_ss_next;
            r_running   <= w_running_next;
            r_crono_end <= w_crono_end_next;
        end
    end

    assign crono_end = r_crono_end;
    assign running   = r_running;
    assign hh        = r_hh;
    assign mm        = r_mm;
    assign ss        = r_ss;

endmodule

// File: tb/tb_crono_timer.sv
module tb_crono_timer;

    logic        clk;
    logic        reset;
    logic        WR_inistop;
    logic [2:0]  inistop;
    logic [7:0]  dir;
    logic        set_en;
    logic [7:0]  set_hh;
    logic [7:0]  set_mm;
    logic [7:0]  set_ss;
    logic        crono_end;
    logic        running;
    logic [7:0]  hh;
    logic [7:0]  mm;
    logic [7:0]  ss;

    crono_timer #(
        .TICK_DIV  (4),
        .CTRL_ADDR (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .WR_inistop (WR_inistop),
        .inistop    (inistop),
        .dir        (dir),
        .set_en     (set_en),
        .set_hh     (set_hh),
        .set_mm     (set_mm),
        .set_ss     (set_ss),
        .crono_end  (crono_end),
        .running    (running),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       run;
        logic       fin;
    } exp_t;

    typedef struct {
        logic       wr;
        logic [2:0] code;
        logic [7:0] d;
        logic       se;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [7:0] eh;
        logic [7:0] em;
        logic [7:0] es;
        logic       er;
        logic       ee;
    } vec_t;

    exp_t sb_q[$];
    vec_t vtab[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] eh, input logic [7:0] em,
                            input logic [7:0] es, input logic er, input logic ee);
        exp_t e;
        e.hh  = eh;
        e.mm  = em;
        e.ss  = es;
        e.run = er;
        e.fin = ee;
        sb_q.push_back(e);
    endtask

    task automatic check_sb(input string label);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s: no expected record queued", label);
        end else begin
            e = sb_q.pop_front();
            if ({hh, mm, ss, running, crono_end} !== {e.hh, e.mm, e.ss, e.run, e.fin}) begin
                bad++;
                $display("FAIL %s: got %h:%h:%h run=%b end=%b, want %h:%h:%h run=%b end=%b",
                         label, hh, mm, ss, running, crono_end,
                         e.hh, e.mm, e.ss, e.run, e.fin);
            end else begin
                $display("ok   %s: %h:%h:%h run=%b end=%b", label, hh, mm, ss, running, crono_end);
            end
        end
    endtask

    task automatic strobe(input logic wr, input logic [2:0] code);
        WR_inistop = wr;
        inistop    = code;
        dir        = 8'h00;
    endtask

    task automatic load_preset(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_en = 1'b1;
        set_hh = h;
        set_mm = m;
        set_ss = s;
        cyc();
        set_en = 1'b0;
    endtask

    // Start from preset, wait exactly one tick, check, then stop.
    task automatic one_tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                            input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                            input string label);
        load_preset(h, m, s);
        strobe(1'b1, 3'b101);
        cyc();
        push_exp(h, m, s, 1'b1, 1'b0);
        check_sb({label, "_start"});
        strobe(1'b0, 3'b101);
        for (int j = 1; j < 4; j++) begin
            cyc();
            push_exp(h, m, s, 1'b1, 1'b0);
            check_sb({label, "_wait"});
        end
        cyc();
        push_exp(eh, em, es, 1'b1, 1'b0);
        check_sb(label);
        strobe(1'b1, 3'b110);
        cyc();
        push_exp(eh, em, es, 1'b0, 1'b0);
        check_sb({label, "_stop"});
        strobe(1'b0, 3'b110);
        cyc();
    endtask

    task automatic addv(input logic wr, input logic [2:0] code, input logic [7:0] d,
                        input logic se, input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s, input logic [7:0] es,
                        input logic er, input logic ee);
        vec_t v;
        v.wr = wr; v.code = code; v.d = d; v.se = se;
        v.h = h; v.m = m; v.s = s;
        v.eh = 8'h00; v.em = 8'h00; v.es = es; v.er = er; v.ee = ee;
        vtab.push_back(v);
    endtask

    initial begin
        reset      = 1'b1;
        WR_inistop = 1'b0;
        inistop    = 3'b000;
        dir        = 8'h00;
        set_en     = 1'b0;
        set_hh     = 8'h00;
        set_mm     = 8'h00;
        set_ss     = 8'h00;

        // ---------------- reset state ----------------
        #12;
        push_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check_sb("reset_state");
        cyc();
        reset = 1'b0;
        cyc();
        cyc();

        // ---------------- 3 s countdown, long strobe ----------------
        load_preset(8'h00, 8'h00, 8'h03);
        strobe(1'b1, 3'b101);
        cyc();
        push_exp(8'h00, 8'h00, 8'h03, 1'b1, 1'b0);
        check_sb("start_3s");
        for (int j = 1; j <= 12; j++) begin
            cyc();
            if (j == 12) push_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
            else         push_exp(8'h00, 8'h00, 8'(3 - j / 4), 1'b1, 1'b0);
            check_sb(j == 12 ? "expiry_12clk" : "countdown");
        end
        // strobe stays high for 257 cycles in total: no second start
        for (int j = 13; j <= 256; j++) begin
            cyc();
            push_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
            check_sb("hold_end_long_strobe");
        end
        strobe(1'b0, 3'b101);
        cyc();
        push_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        check_sb("done_after_release");
        strobe(1'b1, 3'b110);
        cyc();
        push_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check_sb("stop_from_done");
        strobe(1'b0, 3'b110);
        cyc();

        // ---------------- borrow across fields ----------------
        one_tick(8'h01, 8'h00, 8'h00, 8'h00, 8'h59, 8'h59, "borrow_hh");
        one_tick(8'h00, 8'h10, 8'h00, 8'h00, 8'h09, 8'h59, "borrow_mm");

        // ---------------- stop after 3 ticks, restart ----------------
        load_preset(8'h00, 8'h00, 8'h08);
        strobe(1'b1, 3'b101);
        cyc();
        push_exp(8'h00, 8'h00, 8'h08, 1'b1, 1'b0);
        check_sb("start_8s");
        strobe(1'b0, 3'b101);
        for (int j = 1; j <= 12; j++) begin
            cyc();
            if (j % 4 == 0) begin
                push_exp(8'h00, 8'h00, 8'(8 - j / 4), 1'b1, 1'b0);
                check_sb("tick_8s");
            end
        end
        strobe(1'b1, 3'b110);
        cyc();
        push_exp(8'h00, 8'h00, 8'h05, 1'b0, 1'b0);
        check_sb("stop_at_5");
        strobe(1'b0, 3'b110);
        for (int j = 0; j < 20; j++) begin
            cyc();
            push_exp(8'h00, 8'h00, 8'h05, 1'b0, 1'b0);
            check_sb("frozen_5");
        end
        strobe(1'b1, 3'b101);
        cyc();
        push_exp(8'h00, 8'h00, 8'h08, 1'b1, 1'b0);
        check_sb("restart_reload_8");

        // start coincident with prescaler terminal: reload wins
        strobe(1'b0, 3'b101);
        cyc(); cyc(); cyc();
        strobe(1'b1, 3'b101);
        cyc();
        push_exp(8'h00, 8'h00, 8'h08, 1'b1, 1'b0);
        check_sb("start_beats_tick");
        strobe(1'b0, 3'b101);
        cyc(); cyc(); cyc();
        cyc();
        push_exp(8'h00, 8'h00, 8'h07, 1'b1, 1'b0);
        check_sb("tick_after_restart");

        // stop coincident with prescaler terminal: no decrement
        cyc(); cyc(); cyc();
        strobe(1'b1, 3'b110);
        cyc();
        push_exp(8'h00, 8'h00, 8'h07, 1'b0, 1'b0);
        check_sb("stop_beats_tick");
        strobe(1'b0, 3'b110);
        cyc();

        // ---------------- table of ignored / rejected inputs ----------------
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        //    wr    code    dir    se    h      m      s      ess    run   end
        addv(1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 8'h00, 8'h05, 8'h00, 1'b0, 1'b0);
        addv(1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 8'h60, 8'h00, 8'h00, 1'b0, 1'b0);
        addv(1'b1, 3'd5, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        addv(1'b0, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        addv(1'b1, 3'd3, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        addv(1'b0, 3'd3, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        addv(1'b1, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h05, 1'b1, 1'b0);
        addv(1'b0, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h05, 1'b1, 1'b0);
        addv(1'b1, 3'd6, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h05, 1'b0, 1'b0);
        addv(1'b0, 3'd6, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 8'h05, 1'b0, 1'b0);
        addv(1'b1, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        addv(1'b1, 3'd6, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        addv(1'b0, 3'd6, 8'h00, 1'b1, 8'h00, 8'h00, 8'h02, 8'h00, 1'b0, 1'b1);
        addv(1'b1, 3'd5, 8'h00, 1'b1, 8'h00, 8'h00, 8'h09, 8'h02, 1'b1, 1'b0);
        addv(1'b0, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0);
        addv(1'b1, 3'd6, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0);
        addv(1'b0, 3'd6, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0);
        addv(1'b1, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h09, 1'b1, 1'b0);
        addv(1'b0, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h09, 1'b1, 1'b0);
        addv(1'b1, 3'd6, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h09, 1'b0, 1'b0);
        addv(1'b0, 3'd6, 8'h00, 1'b1, 8'h1A, 8'h00, 8'h00, 8'h09, 1'b0, 1'b0);
        addv(1'b0, 3'd6, 8'h00, 1'b1, 8'h00, 8'h00, 8'h60, 8'h09, 1'b0, 1'b0);
        addv(1'b1, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h09, 1'b1, 1'b0);
        addv(1'b0, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h09, 1'b1, 1'b0);
        addv(1'b1, 3'd6, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h09, 1'b0, 1'b0);
        addv(1'b0, 3'd6, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h09, 1'b0, 1'b0);
        for (int i = 0; i < vtab.size(); i++) begin
            WR_inistop = vtab[i].wr;
            inistop    = vtab[i].code;
            dir        = vtab[i].d;
            set_en     = vtab[i].se;
            set_hh     = vtab[i].h;
            set_mm     = vtab[i].m;
            set_ss     = vtab[i].s;
            push_exp(vtab[i].eh, vtab[i].em, vtab[i].es, vtab[i].er, vtab[i].ee);
            cyc();
            check_sb($sformatf("vec%0d", i));
        end
        set_en = 1'b0;
        dir    = 8'h00;

        // ---------------- async reset mid-RUN ----------------
        strobe(1'b1, 3'b101);
        cyc();
        push_exp(8'h00, 8'h00, 8'h09, 1'b1, 1'b0);
        check_sb("pre_reset_start");
        strobe(1'b0, 3'b101);
        for (int j = 0; j < 5; j++) cyc();
        push_exp(8'h00, 8'h00, 8'h08, 1'b1, 1'b0);
        check_sb("pre_reset_tick");
        #2;
        strobe(1'b1, 3'b101);
        reset = 1'b1;
        #1;
        push_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check_sb("async_reset_between_edges");
        cyc();
        cyc();
        reset = 1'b0;
        for (int j = 0; j < 6; j++) begin
            cyc();
            push_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
            check_sb("held_strobe_no_start");
        end
        strobe(1'b0, 3'b101);
        cyc();
        strobe(1'b1, 3'b101);
        cyc();
        push_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        check_sb("rearm_zero_preset_done");
        strobe(1'b0, 3'b101);
        cyc();

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d records left, want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
